sram_port0_ctrl: RTL

- Request/response front end for port 0 (RW) of the 32x256 1RW1R OpenRAM macro.
- Converts a valid/ready request stream into the macro's active-low csb0/web0 pin protocol.
- Captures dout0 in the one-cycle window before it goes X, and returns read data through a 2-entry response FIFO with backpressure.
- After reset, optionally zero-fills the whole array before accepting traffic.

---
 rtl/sram_port0_pkg.sv | 21 ++
 rtl/sram_port0_ctrl_if.sv | 28 ++
 rtl/sram_rsp_fifo2.sv | 53 +++++
 rtl/sram_port0_ctrl.sv | 98 +++++++++
 4 files changed

// File: rtl/sram_port0_pkg.sv
// Shared types and default geometry for the port-0 front end of the 32x256 1RW1R macro.
package sram_port0_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 8;
  localparam int NUM_WMASKS = DATA_WIDTH / 8;
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [NUM_WMASKS-1:0] wmask;
  } req_t;

endpackage

// File: rtl/sram_port0_ctrl_if.sv
// Request/response bundle between a client and the port-0 controller.
interface sram_port0_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_rsp_fifo2.sv
// Two-entry in-order valid/ready FIFO with a registered head and an occupancy count.
module sram_rsp_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             pop;

  assign valid = (count != 2'd0);
  assign pop   = valid && ready;
  assign dout  = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= din;
          else               tail <= din;
          if (count != 2'd2) count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        // Simultaneous push/pop keeps the count; the new word lands behind any survivor.
        2'b11: begin
          if (count == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sram_port0_ctrl.sv
// Port-0 (RW) controller: valid/ready requests to csb0/web0 pins, dout0 capture, optional zero-fill.
module sram_port0_ctrl #(
  parameter int DATA_WIDTH = sram_port0_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = sram_port0_pkg::ADDR_WIDTH,
  parameter int NUM_WMASKS = sram_port0_pkg::NUM_WMASKS,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  sram_port0_ctrl_if.slave      bus,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  import sram_port0_pkg::*;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rd_inflight;
  logic                  rd_fire;
  logic [1:0]            fifo_count;
  logic [1:0]            in_use;
  logic                  credit_ok;

  // A read holds a FIFO slot from acceptance, so the unconditional dout0 capture always fits.
  assign in_use    = fifo_count + {1'b0, rd_inflight};
  assign credit_ok = (in_use < 2'd2);

  always_ff @(posedge clk0) begin
    if (rst0) begin
      if (INIT_EN) state <= INIT;
      else         state <= RUN;
      init_cnt    <= '0;
      rd_inflight <= 1'b0;
      init_done   <= ~INIT_EN;
    end else begin
      state       <= state_next;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
      rd_inflight <= rd_fire;
      init_done   <= (state_next == RUN);
    end
  end

  // Pins stay idle while reset is held so the macro sees no spurious access.
  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    rd_fire       = 1'b0;
    csb0          = 1'b1;
    web0          = 1'b1;
    wmask0        = '0;
    addr0         = '0;
    din0          = '0;
    if (!rst0) begin
      case (state)
        INIT: begin
          csb0   = 1'b0;
          web0   = 1'b0;
          wmask0 = '1;
          addr0  = init_cnt;
          if (&init_cnt) state_next = RUN;
        end
        RUN: begin
          bus.req_ready = credit_ok;
          if (bus.req_valid && credit_ok) begin
            csb0    = 1'b0;
            web0    = ~bus.req_we;
            wmask0  = bus.req_wmask;
            addr0   = bus.req_addr;
            din0    = bus.req_wdata;
            rd_fire = ~bus.req_we;
          end
        end
        default: ;
      endcase
    end
  end

  sram_rsp_fifo2 #(
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk   (clk0),
    .rst   (rst0),
    .push  (rd_inflight),
    .din   (dout0),
    .valid (bus.rsp_valid),
    .ready (bus.rsp_ready),
    .dout  (bus.rsp_rdata),
    .count (fifo_count)
  );

endmodule
